keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter c_Settle_cycles, default 500, cycles each column is driven before its rows are sampled (legal range 3..65535).
REQ-002 SHALL have parameter c_Stable_frames, default 8, consecutive identical frame results required to accept a press or release (legal range 2..255).
REQ-003 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_row  input  4  keypad rows, active-low, asynchronous to i_clk.
REQ-006 SHALL have port o_col  output  4  column drive, active-low one-hot; 4'b1111 means no column driven.
REQ-007 SHALL have port o_key  output  4  accepted key code, row*4 + col.
REQ-008 SHALL have port o_key_valid  output  1  o_key holds an unconsumed event.
REQ-009 SHALL have port i_key_ready  input  1  consumer accepts o_key when high together with o_key_valid.
REQ-010 SHALL have port o_pressed  output  1  level: an accepted key is currently held.
REQ-011 SHALL have port o_overrun  output  1  one-cycle pulse: a new event was dropped.

Function
REQ-012 SHALL pass i_row through a two-flop synchronizer (reset value 4'b1111); all row decisions use the synchronized value.
REQ-013 SHALL implement FSM states DRIVE and EVAL; DRIVE has a 2-bit column index k and a settle counter.
REQ-014 In DRIVE, o_col SHALL equal ~(4'b0001 << k) for exactly c_Settle_cycles cycles; on the last cycle the synchronized rows SHALL be captured for column k.
REQ-015 After capturing k<3, the next cycle SHALL be DRIVE with k+1 and the counter cleared; after k=3, the next cycle SHALL be EVAL.
REQ-016 EVAL SHALL last one cycle with o_col = 4'b1111, then return to DRIVE with k=0; frame length = 4*c_Settle_cycles + 1 cycles.
REQ-017 EVAL SHALL classify the frame's 16 captured bits: NONE (no low bit), SINGLE(code) (exactly one low bit; code = row*4 + col), MULTI (two or more low bits).
REQ-018 The stable counter SHALL reset to 1 when the result differs from the previous frame's result (SINGLE codes compared by value), else increment, saturating at c_Stable_frames.
REQ-019 When the counter reaches c_Stable_frames with result SINGLE(code) and o_pressed=0, the block SHALL set o_pressed and raise an event with code, effective the cycle after EVAL.
REQ-020 When the counter reaches c_Stable_frames with result NONE, o_pressed SHALL clear the cycle after EVAL; no event is raised on release.
REQ-021 A stable MULTI result SHALL neither raise an event nor clear o_pressed; a stable different SINGLE while o_pressed=1 SHALL raise no event (release must be seen first).
REQ-022 An event with o_key_valid=0, or with o_key_valid=1 and i_key_ready=1 in that same cycle, SHALL load o_key and hold o_key_valid=1.
REQ-023 An event with o_key_valid=1 and i_key_ready=0 SHALL be dropped, o_key unchanged, and o_overrun pulsed high for that one cycle.
REQ-024 o_key_valid SHALL clear the cycle after a cycle with o_key_valid=1 and i_key_ready=1 and no simultaneous event; o_key SHALL not change while o_key_valid=1 except per REQ-022.
REQ-025 Scanning SHALL run continuously regardless of handshake state.

Reset
REQ-026 While i_rst=1 at a clock edge: state DRIVE, k=0, counters 0, previous result NONE, synchronizer 4'b1111, o_col=4'b1110, o_key=0, o_key_valid=0, o_pressed=0, o_overrun=0.
REQ-027 Reset asserted mid-frame or with o_key_valid=1 SHALL discard all captured rows and any pending event; the first frame after release starts at k=0 with counter 0.

Verification (c_Settle_cycles=4, c_Stable_frames=3, frame=17 cycles)
REQ-028 No key pressed for 10 frames -> o_col cycles 1110,1101,1011,0111 (4 cycles each) then 1111 (1 cycle); o_key_valid and o_pressed remain 0.
REQ-029 Hold row1/col2 from reset, i_key_ready=1 -> o_key=6, o_key_valid=1 for one cycle and o_pressed=1 the cycle after the 3rd EVAL; release -> o_pressed=0 after 3 NONE frames, no second event.
REQ-030 Key 6 bouncing (toggle every 10 cycles for 2 frames) then steady -> exactly one event, code 6, only after 3 identical steady frames.
REQ-031 i_key_ready=0, press/release key 3, then press key 9 -> o_key stays 3 with o_key_valid=1, o_overrun pulses once at key 9 acceptance; raising i_key_ready clears o_key_valid next cycle.
REQ-032 Keys 0 and 5 held together for 5 frames -> no event, o_pressed unchanged; releasing key 5 -> event code 0 after 3 frames.
REQ-033 Assert i_rst for 1 cycle mid-frame with o_key_valid=1 -> next cycle all outputs at REQ-026 values; held key re-reported after 3 full frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, samples the rows,
// debounces whole-frame results and hands accepted key codes to a consumer.
module keypad_scanner #(
  parameter int c_Settle_cycles = 500,
  parameter int c_Stable_frames = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  output logic       o_pressed,
  output logic       o_overrun
);

  typedef enum logic {
    S_DRIVE,
    S_EVAL
  } state_t;

  typedef enum logic [1:0] {
    R_NONE,
    R_SINGLE,
    R_MULTI
  } result_t;

  localparam logic [15:0] c_SettleLast = 16'(c_Settle_cycles - 1);
  localparam logic [7:0]  c_StableMax  = 8'(c_Stable_frames);

  state_t      r_state;
  logic [1:0]  r_k;
  logic [15:0] r_settle;
  logic [3:0]  r_rowMeta;
  logic [3:0]  r_rowSync;
  logic [15:0] r_cap;
  logic [7:0]  r_stable;
  result_t     r_prevKind;
  logic [3:0]  r_prevCode;

  logic [4:0]  w_lowCount;
  logic [3:0]  w_code;
  result_t     w_kind;
  logic        w_same;
  logic [7:0]  w_stableNext;
  logic        w_settled;
  logic        w_event;
  logic        w_release;

  // r_cap is indexed row*4 + col, so the index of the single low bit is the key code.
  always_comb begin
    w_lowCount = '0;
    w_code     = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!r_cap[i]) begin
        w_lowCount = w_lowCount + 5'd1;
        w_code     = 4'(i);
      end
    end
  end

  always_comb begin
    w_kind = R_NONE;
    if (w_lowCount == 5'd1) begin
      w_kind = R_SINGLE;
    end else if (w_lowCount != 5'd0) begin
      w_kind = R_MULTI;
    end
  end

  assign w_same = (w_kind == r_prevKind) &&
                  ((w_kind != R_SINGLE) || (w_code == r_prevCode));

  assign w_stableNext = !w_same ? 8'd1 :
                        ((r_stable < c_StableMax) ? (r_stable + 8'd1) : r_stable);

  assign w_settled = (w_stableNext == c_StableMax);
  assign w_event   = (r_state == S_EVAL) && w_settled && (w_kind == R_SINGLE) && !o_pressed;
  assign w_release = (r_state == S_EVAL) && w_settled && (w_kind == R_NONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_DRIVE;
      r_k         <= 2'd0;
      r_settle    <= '0;
      r_rowMeta   <= 4'b1111;
      r_rowSync   <= 4'b1111;
      r_cap       <= '1;
      r_stable    <= '0;
      r_prevKind  <= R_NONE;
      r_prevCode  <= '0;
      o_col       <= 4'b1110;
      o_key       <= '0;
      o_key_valid <= 1'b0;
      o_pressed   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      r_rowMeta <= i_row;
      r_rowSync <= r_rowMeta;

      case (r_state)
        S_DRIVE: begin
          if (r_settle == c_SettleLast) begin
            for (int r = 0; r < 4; r++) begin
              r_cap[{2'(r), r_k}] <= r_rowSync[r];
            end
            r_settle <= '0;
            if (r_k == 2'd3) begin
              r_state <= S_EVAL;
              o_col   <= 4'b1111;
            end else begin
              r_k   <= r_k + 2'd1;
              o_col <= ~(4'b0001 << (r_k + 2'd1));
            end
          end else begin
            r_settle <= r_settle + 16'd1;
          end
        end
        S_EVAL: begin
          r_state    <= S_DRIVE;
          r_k        <= 2'd0;
          o_col      <= 4'b1110;
          r_stable   <= w_stableNext;
          r_prevKind <= w_kind;
          r_prevCode <= w_code;
          // A new press is only accepted after a stable release; MULTI never changes o_pressed.
          if (w_event) begin
            o_pressed <= 1'b1;
          end else if (w_release) begin
            o_pressed <= 1'b0;
          end
        end
        default: begin
          r_state <= S_DRIVE;
          r_k     <= 2'd0;
          o_col   <= 4'b1110;
        end
      endcase

      o_overrun <= 1'b0;
      if (w_event) begin
        if (!o_key_valid || i_key_ready) begin
          o_key       <= w_code;
          o_key_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_key_valid && i_key_ready) begin
        o_key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: a key-matrix model drives the rows and a
// frame-level reference model feeds a scoreboard that a per-cycle monitor drains.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int STABLE = 3;
  localparam int FRAME  = 4 * SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        keyValid;
  logic        keyReady = 1'b0;
  logic        pressed;
  logic        overrun;
  logic [15:0] mask = 16'h0000;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(
    .c_Settle_cycles(SETTLE),
    .c_Stable_frames(STABLE)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_row      (row),
    .o_col      (col),
    .o_key      (key),
    .o_key_valid(keyValid),
    .i_key_ready(keyReady),
    .o_pressed  (pressed),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
      end
    end
  end

  int pos = 0;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pos     <= 0;
      started <= 1'b1;
    end else begin
      pos <= (pos == FRAME - 1) ? 0 : pos + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [3:0] expCol(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return (p < 4 * SETTLE) ? ~(one << (p / SETTLE)) : 4'b1111;
  endfunction

  // Reference state: result is -1 for no key, 0..15 for a single key, 16 for several.
  logic [15:0] frameBits = 16'h0000;
  int          prevRes = -1;
  int          stableCnt = 0;
  bit          expPressed = 1'b0;
  bit          expValid = 1'b0;
  bit          expOverrun = 1'b0;
  logic [3:0]  expKey = 4'h0;
  int          overrunCount = 0;
  logic [3:0]  acceptQ[$];

  always @(negedge clk) begin
    int  n;
    int  res;
    bit  ev;
    logic [3:0] code;
    if (started) begin
      checkOutput("col", {12'h0, col}, {12'h0, expCol(pos)});
      checkOutput("pressed", {15'h0, pressed}, {15'h0, expPressed});
      checkOutput("keyValid", {15'h0, keyValid}, {15'h0, expValid});
      checkOutput("overrun", {15'h0, overrun}, {15'h0, expOverrun});
      checkOutput("key", {12'h0, key}, {12'h0, expKey});
      if (keyValid === 1'b1 && keyReady) begin
        if (acceptQ.size() == 0) begin
          checkOutput("consumeUnexpected", {12'h0, key}, 16'hFFFF);
        end else begin
          checkOutput("consumedKey", {12'h0, key}, {12'h0, acceptQ.pop_front()});
        end
      end
    end

    expOverrun = 1'b0;
    if (rst) begin
      prevRes    = -1;
      stableCnt  = 0;
      expPressed = 1'b0;
      expValid   = 1'b0;
      expKey     = 4'h0;
      acceptQ.delete();
    end else begin
      // Rows seen at a column's capture are those present two cycles earlier.
      if (pos < 4 * SETTLE && (pos % SETTLE) == 1) begin
        for (int r = 0; r < 4; r++) frameBits[r*4 + pos/SETTLE] = mask[r*4 + pos/SETTLE];
      end
      ev   = 1'b0;
      code = 4'h0;
      if (pos == FRAME - 1) begin
        n   = $countones(frameBits);
        res = (n == 0) ? -1 : 16;
        if (n == 1) begin
          for (int i = 0; i < 16; i++) if (frameBits[i]) res = i;
        end
        if (res != prevRes) stableCnt = 1;
        else if (stableCnt < STABLE) stableCnt++;
        prevRes = res;
        if (stableCnt == STABLE) begin
          if (res >= 0 && res < 16 && !expPressed) begin
            expPressed = 1'b1;
            ev = 1'b1;
            code = 4'(res);
          end else if (res < 0) begin
            expPressed = 1'b0;
          end
        end
      end
      if (ev) begin
        if (!expValid || keyReady) begin
          expValid = 1'b1;
          expKey   = code;
          acceptQ.push_back(code);
        end else begin
          expOverrun = 1'b1;
          overrunCount++;
        end
      end else if (expValid && keyReady) begin
        expValid = 1'b0;
      end
    end
  end

  // readyMode: 0 = consumer stalled, 1 = always ready, otherwise random per cycle.
  task automatic applyStimulus(input logic [15:0] target, input int cycles, input bit bounce, input int readyMode);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bounce && i < 2 * FRAME) mask = (((i / 10) % 2) == 0) ? target : 16'h0000;
      else mask = target;
      case (readyMode)
        0:       keyReady = 1'b0;
        1:       keyReady = 1'b1;
        default: keyReady = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] target;
    int          sel;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(16'h0000, 10 * FRAME, 1'b0, 1);
    applyStimulus(16'h0040, 5 * FRAME, 1'b0, 1);
    applyStimulus(16'h0000, 5 * FRAME, 1'b0, 1);
    applyStimulus(16'h0040, 6 * FRAME, 1'b1, 1);
    applyStimulus(16'h0000, 5 * FRAME, 1'b0, 1);

    applyStimulus(16'h0008, 5 * FRAME, 1'b0, 0);
    applyStimulus(16'h0000, 5 * FRAME, 1'b0, 0);
    applyStimulus(16'h0200, 5 * FRAME, 1'b0, 0);
    applyStimulus(16'h0200, 2 * FRAME, 1'b0, 1);
    applyStimulus(16'h0000, 5 * FRAME, 1'b0, 1);

    applyStimulus(16'h0021, 5 * FRAME, 1'b0, 1);
    applyStimulus(16'h0001, 5 * FRAME, 1'b0, 1);
    applyStimulus(16'h0000, 5 * FRAME, 1'b0, 1);

    applyStimulus(16'h0040, 4 * FRAME + 7, 1'b0, 0);
    pulseReset();
    applyStimulus(16'h0040, 5 * FRAME, 1'b0, 1);
    applyStimulus(16'h0000, 5 * FRAME, 1'b0, 1);

    for (int seg = 0; seg < 40; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) target = 16'h0000;
      else if (sel < 8) target = 16'h0001 << $urandom_range(0, 15);
      else target = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      applyStimulus(target, FRAME * $urandom_range(1, 6) + $urandom_range(0, FRAME - 1),
                    1'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      if ($urandom_range(0, 14) == 0) pulseReset();
    end

    applyStimulus(16'h0000, 8 * FRAME, 1'b0, 1);
    @(negedge clk);
    checkOutput("queueDrained", 16'(acceptQ.size()), 16'h0000);
    checkOutput("overrunSeen", {15'h0, 1'(overrunCount > 0)}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
